// File: rtl/core_trace_monitor_if.sv
// rtl/core_trace_monitor_if.sv - core bus tap, trace stream and status bundle for core_trace_monitor
interface core_trace_monitor_if #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int CW    = 32
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = 2 + 3 * DW;

  logic          mon_en;
  logic [DW-1:0] pc_out;
  logic          mem_wr;
  logic          mem_rd;
  logic [DW-1:0] alu_Out;
  logic [DW-1:0] reg_Data_2;
  logic [DW-1:0] mem_Data_in;
  logic [EW-1:0] trace_data;
  logic          trace_valid;
  logic          trace_ready;
  logic [LW-1:0] trace_level;
  logic          overflow;
  logic [CW-1:0] drop_count;
  logic          proto_err;
  logic          halted;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] access_count;

  // Core side plus trace consumer: drives the tapped bus and trace_ready
  modport master (
    output mon_en, pc_out, mem_wr, mem_rd, alu_Out, reg_Data_2, mem_Data_in, trace_ready,
    input  trace_data, trace_valid, trace_level, overflow, drop_count, proto_err, halted,
           cycle_count, access_count
  );

  // Monitor side: observes the bus, produces the trace stream and status
  modport slave (
    input  mon_en, pc_out, mem_wr, mem_rd, alu_Out, reg_Data_2, mem_Data_in, trace_ready,
    output trace_data, trace_valid, trace_level, overflow, drop_count, proto_err, halted,
           cycle_count, access_count
  );
endinterface

// File: rtl/core_trace_monitor.sv
// rtl/core_trace_monitor.sv - passive data-memory access tracer with counters and halt detector
module core_trace_monitor #(
  parameter int DW          = 16,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 8,
  parameter int CW          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  core_trace_monitor_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2 + 3 * DW;
  localparam int SW = $clog2(HALT_CYCLES);

  typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          overflow_q, proto_err_q;
  logic [CW-1:0] drop_q, cycle_q, access_q;
  state_t        state_q;
  logic [SW-1:0] stall_cnt_q;
  logic [DW-1:0] pc_q;
  logic          halted_q;

  logic [LW-1:0] level;
  logic          full, valid, pop, access, push, drop, pc_same;
  logic [EW-1:0] entry;

  // Occupancy, handshake and push/drop decisions for this cycle
  always_comb begin
    level   = wr_ptr_q - rd_ptr_q;
    full    = (level == LW'(DEPTH));
    valid   = (level != '0);
    pop     = valid & bus.trace_ready;
    access  = bus.mon_en & (bus.mem_wr | bus.mem_rd);
    push    = access & (~full | pop);
    drop    = access & full & ~pop;
    pc_same = (bus.pc_out == pc_q);
    entry   = {bus.mem_rd, bus.mem_wr, bus.pc_out, bus.alu_Out,
               bus.mem_wr ? bus.reg_Data_2 : bus.mem_Data_in};
  end

  // Trace storage; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= entry;
  end

  // FIFO pointers, sticky flags and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
      drop_q      <= '0;
      cycle_q     <= '0;
      access_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + 1'b1;
      end
      if (access && bus.mem_wr && bus.mem_rd) proto_err_q <= 1'b1;
      if (bus.mon_en && cycle_q != '1) cycle_q <= cycle_q + 1'b1;
      if (access && access_q != '1) access_q <= access_q + 1'b1;
    end
  end

  // Halt detector: counts consecutive unchanged PC samples while enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      pc_q        <= '0;
      halted_q    <= 1'b0;
    end else if (bus.mon_en) begin
      pc_q <= bus.pc_out;
      case (state_q)
        RUN: if (pc_same) begin
          stall_cnt_q <= SW'(1);
          if (SW'(1) == SW'(HALT_CYCLES - 1)) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else begin
            state_q <= STALL;
          end
        end
        STALL: if (!pc_same) begin
          state_q     <= RUN;
          stall_cnt_q <= '0;
        end else begin
          stall_cnt_q <= stall_cnt_q + SW'(1);
          if (stall_cnt_q + SW'(1) == SW'(HALT_CYCLES - 1)) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: if (!pc_same) begin
          state_q     <= RUN;
          stall_cnt_q <= '0;
          halted_q    <= 1'b0;
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trace_data   = valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign bus.trace_valid  = valid;
  assign bus.trace_level  = level;
  assign bus.overflow     = overflow_q;
  assign bus.drop_count   = drop_q;
  assign bus.proto_err    = proto_err_q;
  assign bus.halted       = halted_q;
  assign bus.cycle_count  = cycle_q;
  assign bus.access_count = access_q;
endmodule

// File: tb/tb_core_trace_monitor.sv
// tb/tb_core_trace_monitor.sv - directed bench with queue-based reference model for core_trace_monitor
module tb_core_trace_monitor;
  localparam int DW = 16, DEPTH = 16, HC = 8, CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  core_trace_monitor_if #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) bus ();

  core_trace_monitor #(.DW(DW), .DEPTH(DEPTH), .HALT_CYCLES(HC), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [49:0] mq[$];
  longint      m_cycle, m_access, m_drop;
  logic        m_ovf, m_perr;
  logic [15:0] m_prev_pc;
  int          m_run;
  localparam longint SAT = (64'd1 << CW) - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: access list semantics, pop before push, streak of equal PC samples
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_cycle = 0; m_access = 0; m_drop = 0;
      m_ovf = 0; m_perr = 0; m_prev_pc = 0; m_run = 0;
    end else begin
      automatic bit was_full = (mq.size() == DEPTH);
      automatic bit do_pop = (mq.size() != 0) && bus.trace_ready;
      if (do_pop) void'(mq.pop_front());
      if (bus.mon_en) begin
        if (m_cycle < SAT) m_cycle++;
        if (bus.mem_wr || bus.mem_rd) begin
          if (m_access < SAT) m_access++;
          if (bus.mem_wr && bus.mem_rd) m_perr = 1;
          if (!was_full || do_pop)
            mq.push_back({bus.mem_rd, bus.mem_wr, bus.pc_out, bus.alu_Out,
                          bus.mem_wr ? bus.reg_Data_2 : bus.mem_Data_in});
          else begin
            m_ovf = 1;
            if (m_drop < SAT) m_drop++;
          end
        end
        if (bus.pc_out == m_prev_pc) begin
          if (m_run < 1000) m_run++;
        end else m_run = 0;
        m_prev_pc = bus.pc_out;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("valid", 64'(bus.trace_valid), 64'(mq.size() != 0));
    chk("data", 64'(bus.trace_data), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
    chk("level", 64'(bus.trace_level), 64'(mq.size()));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("drop_count", 64'(bus.drop_count), 64'(m_drop));
    chk("proto_err", 64'(bus.proto_err), 64'(m_perr));
    chk("halted", 64'(bus.halted), 64'(m_run >= HC - 1));
    chk("cycle_count", 64'(bus.cycle_count), 64'(m_cycle));
    chk("access_count", 64'(bus.access_count), 64'(m_access));
  end

  task automatic drive(input logic en, wr, rd, input logic [15:0] pc, addr, wd, rdat,
                       input logic rdy);
    bus.mon_en = en; bus.mem_wr = wr; bus.mem_rd = rd; bus.pc_out = pc;
    bus.alu_Out = addr; bus.reg_Data_2 = wd; bus.mem_Data_in = rdat; bus.trace_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, rdy);
    rst = 1'b0;
  endtask

  initial begin
    bus.mon_en = 0; bus.mem_wr = 0; bus.mem_rd = 0; bus.pc_out = 0;
    bus.alu_Out = 0; bus.reg_Data_2 = 0; bus.mem_Data_in = 0; bus.trace_ready = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("lit_reset_valid", 64'(bus.trace_valid), 64'd0);
    chk("lit_reset_data", 64'(bus.trace_data), 64'd0);
    chk("lit_reset_level", 64'(bus.trace_level), 64'd0);

    // Single write then pop
    drive(1, 1, 0, 16'h0012, 16'h0040, 16'hBEEF, 16'h0, 0);
    chk("lit_wr_valid", 64'(bus.trace_valid), 64'd1);
    chk("lit_wr_data", 64'(bus.trace_data), 64'({2'b01, 16'h0012, 16'h0040, 16'hBEEF}));
    chk("lit_wr_level", 64'(bus.trace_level), 64'd1);
    chk("lit_wr_cycle", 64'(bus.cycle_count), 64'd1);
    drive(1, 0, 0, 16'h0013, 16'h0, 16'h0, 16'h0, 1);
    chk("lit_pop_level", 64'(bus.trace_level), 64'd0);

    // Fill past capacity with reads
    do_reset(0);
    for (int i = 0; i < 18; i++)
      drive(1, 0, 1, 16'(16'h0200 + i), 16'(i), 16'h0, 16'(16'h0100 + i), 0);
    chk("lit_fill_level", 64'(bus.trace_level), 64'd16);
    chk("lit_fill_ovf", 64'(bus.overflow), 64'd1);
    chk("lit_fill_drop", 64'(bus.drop_count), 64'd2);
    chk("lit_fill_access", 64'(bus.access_count), 64'd18);
    chk("lit_fill_head", 64'(bus.trace_data), 64'({2'b10, 16'h0200, 16'h0000, 16'h0100}));

    // Full with simultaneous push and pop
    drive(1, 0, 1, 16'h0212, 16'h0012, 16'h0, 16'h0112, 1);
    chk("lit_pp_level", 64'(bus.trace_level), 64'd16);
    chk("lit_pp_drop", 64'(bus.drop_count), 64'd2);
    chk("lit_pp_head", 64'(bus.trace_data), 64'({2'b10, 16'h0201, 16'h0001, 16'h0101}));
    for (int i = 0; i < 15; i++)
      drive(1, 0, 0, 16'h0300, 16'h0, 16'h0, 16'h0, 1);
    chk("lit_last_out", 64'(bus.trace_data), 64'({2'b10, 16'h0212, 16'h0012, 16'h0112}));
    drive(1, 0, 0, 16'h0301, 16'h0, 16'h0, 16'h0, 1);
    chk("lit_drained", 64'(bus.trace_level), 64'd0);

    // Protocol error
    drive(1, 1, 1, 16'h0050, 16'h0060, 16'h1234, 16'h5678, 0);
    chk("lit_perr_data", 64'(bus.trace_data), 64'({2'b11, 16'h0050, 16'h0060, 16'h1234}));
    chk("lit_perr", 64'(bus.proto_err), 64'd1);
    for (int i = 0; i < 3; i++)
      drive(1, 0, 0, 16'(16'h0051 + i), 16'h0, 16'h0, 16'h0, 1);
    chk("lit_perr_sticky", 64'(bus.proto_err), 64'd1);

    // Halt detection and a 7-sample stall that must not halt
    do_reset(0);
    chk("lit_perr_cleared", 64'(bus.proto_err), 64'd0);
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 16'h0020, 16'h0, 16'h0, 16'h0, 0);
    chk("lit_halt_7", 64'(bus.halted), 64'd0);
    drive(1, 0, 0, 16'h0020, 16'h0, 16'h0, 16'h0, 0);
    chk("lit_halt_8", 64'(bus.halted), 64'd1);
    drive(1, 0, 0, 16'h0021, 16'h0, 16'h0, 16'h0, 0);
    chk("lit_halt_release", 64'(bus.halted), 64'd0);
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 16'h0022, 16'h0, 16'h0, 16'h0, 0);
    chk("lit_stall7", 64'(bus.halted), 64'd0);
    drive(1, 0, 0, 16'h0023, 16'h0, 16'h0, 16'h0, 0);
    chk("lit_stall7_after", 64'(bus.halted), 64'd0);

    // Reset mid-stream, then disabled cycles
    for (int i = 0; i < 5; i++)
      drive(1, 1, 0, 16'(16'h0400 + i), 16'(i), 16'(16'hA000 + i), 16'h0, 0);
    chk("lit_mid_level", 64'(bus.trace_level), 64'd5);
    do_reset(1);
    chk("lit_rst_level", 64'(bus.trace_level), 64'd0);
    chk("lit_rst_valid", 64'(bus.trace_valid), 64'd0);
    chk("lit_rst_access", 64'(bus.access_count), 64'd0);
    chk("lit_rst_cycle", 64'(bus.cycle_count), 64'd0);
    for (int i = 0; i < 3; i++)
      drive(0, 1, 0, 16'h0500, 16'h0001, 16'h0002, 16'h0, 0);
    chk("lit_dis_cycle", 64'(bus.cycle_count), 64'd0);
    chk("lit_dis_access", 64'(bus.access_count), 64'd0);
    chk("lit_dis_level", 64'(bus.trace_level), 64'd0);
    drive(1, 0, 0, 16'h0501, 16'h0, 16'h0, 16'h0, 0);
    chk("lit_en_cycle", 64'(bus.cycle_count), 64'd1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
